// File: rtl/peridot_pfc_initiator.sv
// peridot_pfc_initiator: Avalon-MM master that writes and optionally verifies the PFC dout/funcsel/pinsel registers
module peridot_pfc_initiator #(
  parameter logic [7:0]  DOUT_INIT      = 8'h00,
  parameter logic [31:0] FUNC_INIT      = 32'h00000000,
  parameter logic [31:0] PIN_INIT       = 32'h00000000,
  parameter bit          VERIFY         = 1'b1,
  parameter bit          AUTO_START     = 1'b1,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        csi_clk,
  input  logic        rsi_reset,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        coe_start,
  output logic        coe_busy,
  output logic        coe_done,
  output logic [3:0]  coe_error
);
  typedef enum logic [2:0] {IDLE, WR_DOUT, WR_FUNC, WR_PIN, RD_DOUT, RD_FUNC, RD_PIN, DONE} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t state, state_nxt;
  logic pend, start, restart, accept, stall, expire;
  logic [15:0] cnt;
  logic [3:0] err_set;
  logic [1:0] addr_nxt;
  logic [31:0] wdata_nxt;
  always_comb begin
    start = coe_start | pend;
    restart = start & (state == IDLE || state == DONE);
    accept = (avm_read | avm_write) & ~avm_waitrequest;
    stall = (avm_read | avm_write) & avm_waitrequest;
    expire = (TIMEOUT_CYCLES != 0) && stall && cnt == TO_LAST;
    state_nxt = state;
    err_set = '0;
    case (state)
      IDLE, DONE: if (start) state_nxt = WR_DOUT;
      WR_DOUT:    if (accept) state_nxt = WR_FUNC;
      WR_FUNC:    if (accept) state_nxt = WR_PIN;
      WR_PIN:     if (accept) state_nxt = VERIFY ? RD_DOUT : DONE;
      RD_DOUT: begin
        if (accept) state_nxt = RD_FUNC;
        err_set[0] = accept && avm_readdata[7:0] != DOUT_INIT;
      end
      RD_FUNC: begin
        if (accept) state_nxt = RD_PIN;
        err_set[1] = accept && avm_readdata != FUNC_INIT;
      end
      RD_PIN: begin
        if (accept) state_nxt = DONE;
        err_set[2] = accept && avm_readdata != PIN_INIT;
      end
    endcase
    if (expire) state_nxt = DONE;
    err_set[3] = expire;
    addr_nxt = (state_nxt == WR_DOUT || state_nxt == RD_DOUT) ? 2'd1 :
               (state_nxt == WR_FUNC || state_nxt == RD_FUNC) ? 2'd3 :
               (state_nxt == WR_PIN  || state_nxt == RD_PIN)  ? 2'd2 : 2'd0;
    wdata_nxt = (state_nxt == WR_DOUT) ? {24'h000000, DOUT_INIT} :
                (state_nxt == WR_FUNC) ? FUNC_INIT :
                (state_nxt == WR_PIN)  ? PIN_INIT : 32'h00000000;
  end
  // Outputs are registered from the next state so the command is stable while stalled.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state <= IDLE;
      pend <= AUTO_START;
      cnt <= '0;
      avm_address <= '0;
      avm_read <= 1'b0;
      avm_write <= 1'b0;
      avm_writedata <= '0;
      coe_busy <= 1'b0;
      coe_done <= 1'b0;
      coe_error <= '0;
    end else begin
      state <= state_nxt;
      pend <= 1'b0;
      cnt <= stall ? cnt + 16'd1 : 16'd0;
      avm_address <= addr_nxt;
      avm_write <= state_nxt inside {WR_DOUT, WR_FUNC, WR_PIN};
      avm_read <= state_nxt inside {RD_DOUT, RD_FUNC, RD_PIN};
      avm_writedata <= wdata_nxt;
      coe_busy <= !(state_nxt == IDLE || state_nxt == DONE);
      coe_done <= state_nxt == DONE;
      coe_error <= restart ? 4'h0 : coe_error | err_set;
    end
  end
endmodule

// File: tb/tb_peridot_pfc_initiator.sv
// tb_peridot_pfc_initiator: directed checks of the PFC initiator against a small PFC register model
module tb_peridot_pfc_initiator;
  localparam logic [7:0]  AD = 8'h5A;
  localparam logic [31:0] AF = 32'h1234_5678;
  localparam logic [31:0] AP = 32'h0000_00F0;
  localparam logic [7:0]  BD = 8'hC3;
  localparam logic [31:0] BF = 32'hA5A5_0F0F;
  localparam logic [31:0] BP = 32'h8000_0001;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] a_addr, b_addr;
  logic a_read, a_write, b_read, b_write;
  logic [31:0] a_wdata, a_rdata, b_wdata;
  logic a_wait = 1'b0, a_start = 1'b0, b_start = 1'b0;
  logic a_busy, a_done, b_busy, b_done;
  logic [3:0] a_err, b_err;
  logic [31:0] a_regs [4];
  logic corrupt = 1'b0;
  int total = 0, passed = 0, fails = 0;
  peridot_pfc_initiator #(.DOUT_INIT(AD), .FUNC_INIT(AF), .PIN_INIT(AP), .VERIFY(1'b1),
    .AUTO_START(1'b1), .TIMEOUT_CYCLES(4)) dut_a (
    .csi_clk(clk), .rsi_reset(rst), .avm_address(a_addr), .avm_read(a_read), .avm_write(a_write),
    .avm_writedata(a_wdata), .avm_readdata(a_rdata), .avm_waitrequest(a_wait),
    .coe_start(a_start), .coe_busy(a_busy), .coe_done(a_done), .coe_error(a_err));
  peridot_pfc_initiator #(.DOUT_INIT(BD), .FUNC_INIT(BF), .PIN_INIT(BP), .VERIFY(1'b0),
    .AUTO_START(1'b0), .TIMEOUT_CYCLES(255)) dut_b (
    .csi_clk(clk), .rsi_reset(rst), .avm_address(b_addr), .avm_read(b_read), .avm_write(b_write),
    .avm_writedata(b_wdata), .avm_readdata(32'h0), .avm_waitrequest(1'b0),
    .coe_start(b_start), .coe_busy(b_busy), .coe_done(b_done), .coe_error(b_err));
  always @(posedge clk) if (a_write && !a_wait) a_regs[a_addr] <= a_wdata;
  assign a_rdata = a_regs[a_addr] ^ {31'h0, corrupt && a_addr == 2'd3};
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string t, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", t, got, exp);
    end
  endtask
  task automatic sa(string t, logic w, logic r, logic b, logic d, logic [3:0] e, logic [1:0] ad, logic [31:0] wd);
    chk({t, "_ctl"}, {24'h0, a_write, a_read, a_busy, a_done, a_err}, {24'h0, w, r, b, d, e});
    if (w || r) chk({t, "_adr"}, {30'h0, a_addr}, {30'h0, ad});
    if (w) chk({t, "_wd"}, a_wdata, wd);
  endtask
  task automatic sb(string t, logic w, logic r, logic b, logic d, logic [1:0] ad, logic [31:0] wd);
    chk({t, "_ctl"}, {24'h0, b_write, b_read, b_busy, b_done, b_err}, {24'h0, w, r, b, d, 4'h0});
    if (w || r) chk({t, "_adr"}, {30'h0, b_addr}, {30'h0, ad});
    if (w) chk({t, "_wd"}, b_wdata, wd);
  endtask
  initial begin
    tick(2);
    chk("a_reset", {22'h0, a_write, a_read, a_busy, a_done, a_err, a_addr}, 32'h0);
    chk("a_reset_wd", a_wdata, 32'h0);
    chk("b_reset", {22'h0, b_write, b_read, b_busy, b_done, b_err, b_addr}, 32'h0);
    // auto start after reset release
    rst = 1'b0;
    tick(); sa("t1_c1", 1, 0, 1, 0, 4'h0, 2'd1, {24'h0, AD});
    tick(); sa("t1_c2", 1, 0, 1, 0, 4'h0, 2'd3, AF);
    tick(); sa("t1_c3", 1, 0, 1, 0, 4'h0, 2'd2, AP);
    tick(); sa("t1_c4", 0, 1, 1, 0, 4'h0, 2'd1, 32'h0);
    tick(); sa("t1_c5", 0, 1, 1, 0, 4'h0, 2'd3, 32'h0);
    tick(); sa("t1_c6", 0, 1, 1, 0, 4'h0, 2'd2, 32'h0);
    tick(); sa("t1_c7", 0, 0, 0, 1, 4'h0, 2'd0, 32'h0);
    chk("reg1", a_regs[1], 32'h0000_005A);
    chk("reg3", a_regs[3], AF);
    chk("reg2", a_regs[2], AP);
    chk("b_idle", {29'h0, b_busy, b_done, b_write}, 32'h0);
    // corrupted funcsel readback
    corrupt = 1'b1; a_start = 1'b1;
    tick(); a_start = 1'b0; sa("t2_c1", 1, 0, 1, 0, 4'h0, 2'd1, {24'h0, AD});
    tick(6); sa("t2_c7", 0, 0, 0, 1, 4'b0010, 2'd0, 32'h0);
    // clean rerun with 3 stall cycles on WR_FUNC
    corrupt = 1'b0; a_start = 1'b1;
    tick(); a_start = 1'b0; sa("t3_c1", 1, 0, 1, 0, 4'h0, 2'd1, {24'h0, AD});
    tick(); sa("t3_c2", 1, 0, 1, 0, 4'h0, 2'd3, AF); a_wait = 1'b1;
    tick(); sa("t3_c3", 1, 0, 1, 0, 4'h0, 2'd3, AF);
    tick(); sa("t3_c4", 1, 0, 1, 0, 4'h0, 2'd3, AF);
    tick(); sa("t3_c5", 1, 0, 1, 0, 4'h0, 2'd3, AF); a_wait = 1'b0;
    tick(); sa("t3_c6", 1, 0, 1, 0, 4'h0, 2'd2, AP);
    tick(3); sa("t3_c9", 0, 1, 1, 0, 4'h0, 2'd2, 32'h0);
    tick(); sa("t3_c10", 0, 0, 0, 1, 4'h0, 2'd0, 32'h0);
    // timeout on WR_PIN after 4 stall cycles
    a_start = 1'b1;
    tick(); a_start = 1'b0;
    tick();
    tick(); sa("t4_c3", 1, 0, 1, 0, 4'h0, 2'd2, AP); a_wait = 1'b1;
    tick(); sa("t4_c4", 1, 0, 1, 0, 4'h0, 2'd2, AP);
    tick(); sa("t4_c5", 1, 0, 1, 0, 4'h0, 2'd2, AP);
    tick(); sa("t4_c6", 1, 0, 1, 0, 4'h0, 2'd2, AP);
    tick(); sa("t4_c7", 0, 0, 0, 1, 4'b1000, 2'd0, 32'h0);
    a_wait = 1'b0;
    tick(3); sa("t4_c10", 0, 0, 0, 1, 4'b1000, 2'd0, 32'h0);
    // start pulse during RD_DOUT is ignored
    a_start = 1'b1;
    tick(); a_start = 1'b0; sa("t5_c1", 1, 0, 1, 0, 4'h0, 2'd1, {24'h0, AD});
    tick(3); sa("t5_c4", 0, 1, 1, 0, 4'h0, 2'd1, 32'h0); a_start = 1'b1;
    tick(); a_start = 1'b0; sa("t5_c5", 0, 1, 1, 0, 4'h0, 2'd3, 32'h0);
    tick(); sa("t5_c6", 0, 1, 1, 0, 4'h0, 2'd2, 32'h0);
    tick(); sa("t5_c7", 0, 0, 0, 1, 4'h0, 2'd0, 32'h0);
    tick(); sa("t5_c8", 0, 0, 0, 1, 4'h0, 2'd0, 32'h0);
    // reset during WR_FUNC, release coinciding with coe_start
    a_start = 1'b1;
    tick(); a_start = 1'b0;
    tick(); sa("t6_c2", 1, 0, 1, 0, 4'h0, 2'd3, AF);
    rst = 1'b1;
    #1 chk("t6_async", {22'h0, a_write, a_read, a_busy, a_done, a_err, a_addr}, 32'h0);
    chk("t6_async_wd", a_wdata, 32'h0);
    tick(2); rst = 1'b0; a_start = 1'b1;
    tick(); a_start = 1'b0; sa("t6_r1", 1, 0, 1, 0, 4'h0, 2'd1, {24'h0, AD});
    chk("t6_b_idle", {30'h0, b_busy, b_write}, 32'h0);
    tick(6); sa("t6_r7", 0, 0, 0, 1, 4'h0, 2'd0, 32'h0);
    tick(); sa("t6_r8", 0, 0, 0, 1, 4'h0, 2'd0, 32'h0);
    // VERIFY=0, AUTO_START=0 instance: three writes only
    b_start = 1'b1;
    tick(); b_start = 1'b0; sb("b_c1", 1, 0, 1, 0, 2'd1, {24'h0, BD});
    tick(); sb("b_c2", 1, 0, 1, 0, 2'd3, BF);
    tick(); sb("b_c3", 1, 0, 1, 0, 2'd2, BP);
    tick(); sb("b_c4", 0, 0, 0, 1, 2'd0, 32'h0);
    tick(2); sb("b_c6", 0, 0, 0, 1, 2'd0, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/peridot_pfc_initiator.md
# peridot_pfc_initiator

Avalon-MM master that programs a pin function controller (PFC) register slave after reset or on request. It writes the output-data, function-select and pin-select registers from build-time constants, optionally reads them back to verify, and reports busy/done/error to the system. It sits between the PFC slave port and boot/board-management logic, so pin muxing is valid before any CPU runs.

## Interface

Parameters:
- `DOUT_INIT`, 8'h00: value written to PFC reg01 dout.
- `FUNC_INIT`, 32'h00000000: value written to PFC reg03 funcsel.
- `PIN_INIT`, 32'h00000000: value written to PFC reg02 pinsel.
- `VERIFY`, 1: 1 performs readback compare after the writes; 0 skips it.
- `AUTO_START`, 1: 1 runs the sequence once after reset release.
- `TIMEOUT_CYCLES`, 255: maximum cycles a command may be held by waitrequest, 1-65535; 0 disables the timeout.

Ports:
- `csi_clk`  in  1  sole clock; all logic posedge.
- `rsi_reset`  in  1  asynchronous, active-high reset.
- `avm_address`  out  2  PFC register index.
- `avm_read`  out  1  read command.
- `avm_write`  out  1  write command.
- `avm_writedata`  out  32  write data.
- `avm_readdata`  in  32  read data; valid in the cycle the read is accepted (zero read latency).
- `avm_waitrequest`  in  1  slave stall.
- `coe_start`  in  1  single-cycle start request.
- `coe_busy`  out  1  sequence in progress.
- `coe_done`  out  1  sequence finished; sticky until the next start.
- `coe_error`  out  4  sticky error flags: [0] dout mismatch, [1] funcsel mismatch, [2] pinsel mismatch, [3] timeout.

## Operation

- FSM states: IDLE, WR_DOUT, WR_FUNC, WR_PIN, RD_DOUT, RD_FUNC, RD_PIN, DONE.
- Write order is fixed: dout, then funcsel, then pinsel. Pins therefore switch to output only after their data and function routing are set.
- WR_DOUT: address 1, writedata = {16'h0000, 8'h00, DOUT_INIT}. Mask 0 means all 8 bits are written.
- WR_FUNC: address 3, writedata = FUNC_INIT.
- WR_PIN: address 2, writedata = PIN_INIT.
- Read states use addresses 1, 3, 2 in that order. Compare rules:
  - RD_DOUT compares only readdata[7:0] against DOUT_INIT.
  - RD_FUNC and RD_PIN compare all 32 bits.
  - A mismatch sets the matching error bit and the sequence continues.
- VERIFY=0: WR_PIN goes directly to DONE.
- A transfer is accepted on a clock edge where the command is high and waitrequest is low. The next state's command is driven in the following cycle with no idle gap.
- Exactly one of avm_read/avm_write is high in the command states. Both are low in IDLE and DONE.
- Address, writedata and command are registered and held stable while waitrequest is high.
- Timeout (TIMEOUT_CYCLES≠0):
  - A 16-bit counter clears on each accept and increments each cycle waitrequest stalls a command.
  - When the counter reaches TIMEOUT_CYCLES with waitrequest still high, the command drops, error[3] sets, and the FSM goes to DONE. No further transfers are issued.
- Start handling:
  - coe_start in IDLE or DONE clears done and error and enters WR_DOUT.
  - coe_start while busy is ignored.
- AUTO_START=1: a pending-start flag set by reset behaves as a coe_start in the first cycle after reset release.
- busy is high in every command state. done is high only in DONE.

## Timing

- Reset values: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, coe_busy=0, coe_done=0, coe_error=0, state=IDLE, timeout counter=0.
- Outputs are registered. Start is sampled at edge N; the command and busy appear after edge N, in cycle N+1.
- With waitrequest tied low and VERIFY=1: 6 transfers occupy cycles N+1..N+6, and done=1 from cycle N+7.
- With VERIFY=0: 3 transfers, and done=1 from cycle N+4.
- Each waitrequest stall cycle extends the sequence by one cycle.
- Reset asserted mid-sequence: outputs return to reset values immediately (asynchronously). The pending transfer is abandoned. After release, AUTO_START governs a full rerun from WR_DOUT.
- coe_start coinciding with reset release while AUTO_START=1 produces one run, not two.

## Test plan

- AUTO_START=1, VERIFY=1, waitrequest=0, model PFC: after reset release, writes (1,0x0000005A),(3,FUNC_INIT),(2,PIN_INIT) occur in cycles 1-3, reads 1,3,2 in cycles 4-6, done=1 at cycle 7, error=0.
- Model corrupts reg03 readback bit 0: error=4'b0010 and done=1. A later coe_start clears error and the sequence repeats cleanly.
- waitrequest held high 3 cycles on WR_FUNC: address/writedata/write stable throughout, and total completion is delayed by exactly 3 cycles.
- TIMEOUT_CYCLES=4, waitrequest stuck high at WR_PIN: command drops after the 4th stall cycle, error=4'b1000, done=1, and no read is issued.
- coe_start pulsed during RD_DOUT: ignored, and the sequence length is unchanged. Reset asserted at WR_FUNC: outputs are 0 immediately, and after release a rerun starts from WR_DOUT.
- VERIFY=0, AUTO_START=0: idle until coe_start; only 3 writes occur and done=1 at start+4.
